trit_group_packer: RTL and testbench
====================================

# trit_group_packer

Upstream feeder for the 5-trit-to-byte converter in the NTRU-HRSS S3 packing path. Accepts a polynomial's trit coefficients one at a time over a valid/ready stream, assembles them into 10-bit 5-trit groups, and presents each group on a valid/ready output. The converter's control logic takes each group, loads it, and produces one byte per group. The final group is zero-padded when N_TRITS is not a multiple of 5. The block also flags illegal trit encodings.

## Interface
- N_TRITS, 700, coefficients per polynomial; legal range 1..1275.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  begin a new polynomial; honoured only in IDLE.
- trit_in  input  2  coefficient encoding: 2'b00=0, 2'b01=1, 2'b11=2; 2'b10 is illegal.
- trit_valid  input  1  trit_in is valid.
- trit_ready  output  1  block accepts a trit this cycle.
- grp  output  10  assembled group: [1:0]=trit 5i (weight 1), [3:2]=5i+1 (weight 3), [5:4]=5i+2 (weight 9), [7:6]=5i+3 (weight 27), [9:8]=5i+4 (weight 81).
- grp_valid  output  1  grp is valid.
- grp_ready  input  1  downstream accepts grp.
- grp_last  output  1  grp is the final group of the polynomial; qualified by grp_valid.
- grp_index  output  8  group number 0..ceil(N_TRITS/5)-1; qualified by grp_valid.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse after the last group is accepted.
- err_illegal  output  1  sticky flag: an illegal encoding was accepted; cleared on start.

## Operation
- States: IDLE, FILL, HOLD, DONE.
- IDLE
  - trit_ready=0, grp_valid=0.
  - start=1: clear the slot pointer (0..4), the trit counter and grp_index; clear the group register to 0; clear err_illegal; go to FILL.
- FILL
  - trit_ready=1.
  - A trit is accepted when trit_valid&trit_ready. It is written to the slot at grp[2*pos+1:2*pos]. pos and the trit counter increment.
  - An accepted 2'b10 is stored as 2'b00 and sets err_illegal.
  - Leave for HOLD on the accepted trit where pos==4, or where the trit counter reaches N_TRITS (partial group).
  - Slots not written since the last clear stay 2'b00 (zero padding).
- HOLD
  - trit_ready=0, grp_valid=1.
  - grp, grp_last and grp_index are held stable until grp_valid&grp_ready.
  - grp_last=1 iff the trit counter equals N_TRITS.
  - On acceptance, not last: clear grp and pos, increment grp_index, go to FILL.
  - On acceptance, last: go to DONE.
- DONE
  - done=1 for exactly one cycle, then IDLE.
  - err_illegal keeps its value.
- start outside IDLE is ignored.
- trit_valid outside FILL is ignored; no trit is consumed.
- Group count is ceil(N_TRITS/5). For the default N_TRITS=700 this is 140 groups with no padding.

## Timing
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE.
  - trit_ready=0, grp_valid=0, grp_last=0, grp=0, grp_index=0, busy=0, done=0, err_illegal=0.
  - pos and the trit counter go to 0.
- Reset mid-operation aborts the polynomial. A group held in HOLD is dropped, and done is not pulsed.
- start is sampled in cycle t; trit_ready=1 from cycle t+1.
- The group-completing trit is accepted in cycle k; grp_valid=1 from cycle k+1. trit_ready=0 in cycle k+1.
- grp accepted in cycle h:
  - trit_ready=1 in h+1 if not last.
  - If last, done=1 in h+1 and busy=0 in h+2.
- Peak throughput: 5 trits per 6 cycles. Group acceptance and trit acceptance never occur in the same cycle.
- grp_valid, once high, stays high until accepted, whatever trit_valid or start do.

## Test plan
- **Basic group.** N_TRITS=5, start, then trits 01,11,00,01,11 with valid held high.
  - grp=10'b11_01_00_11_01, grp_last=1, grp_index=0, one cycle after the 5th accept.
  - done pulses one cycle after grp accept.
- **Padding.** N_TRITS=12, all trits 2'b01.
  - Three groups: grp=10'h155 (index 0), 10'h155 (index 1), 10'b00_00_00_01_01 with grp_last=1 (index 2).
- **Backpressure.** Hold grp_ready=0 for 7 cycles on group 0.
  - grp_valid, grp and grp_index stay stable.
  - trit_ready=0 throughout; no trit is consumed.
  - Resume: the next trit lands in slot 0 of group 1.
- **Illegal encoding.** Feed 2'b10 as trit 2.
  - That slot reads 2'b00 and err_illegal=1 until the next start.
  - A following clean polynomial clears err_illegal on start.
- **Full polynomial.** Default N_TRITS=700, random legal trits, random valid/ready gaps.
  - 140 groups with index 0..139; grp_last only on index 139.
  - Each grp, interpreted as base-3 (converted to a byte), matches the software model; all values ≤ 242.
- **Reset and start.** Deassert rst_n while in HOLD during group 3.
  - All outputs return to reset values next cycle.
  - start during FILL is ignored, and the polynomial continues unchanged.

Source files
------------

// File: rtl/trit_group_packer.sv
// trit_group_packer
// Collects 2-bit trit codes from a valid/ready stream into 10-bit groups of
// five trits and hands each group to the trit-to-byte converter over a second
// valid/ready stream. The final group of a polynomial is zero padded when the
// coefficient count is not a multiple of five. Illegal code 2'b10 is stored
// as zero and raises a sticky error flag.
module trit_group_packer #(
    parameter int N_TRITS = 700  // coefficients per polynomial, 1..1275
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] trit_in,
    input  logic       trit_valid,
    output logic       trit_ready,
    output logic [9:0] grp,
    output logic       grp_valid,
    input  logic       grp_ready,
    output logic       grp_last,
    output logic [7:0] grp_index,
    output logic       busy,
    output logic       done,
    output logic       err_illegal
);

    // 11 bits cover the largest legal polynomial (1275 coefficients).
    localparam logic [10:0] N_LAST = 11'(N_TRITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  pos_q,   pos_d;    // next slot to fill, 0..4
    logic [10:0] cnt_q,   cnt_d;    // trits accepted for this polynomial
    logic [9:0]  grp_q,   grp_d;    // group under assembly / on offer
    logic [7:0]  idx_q,   idx_d;    // group number
    logic        err_q,   err_d;    // sticky illegal-code flag

    logic [1:0]  trit_clean;        // incoming code with 2'b10 forced to zero
    logic        trit_bad;

    assign trit_bad   = (trit_in == 2'b10);
    assign trit_clean = trit_bad ? 2'b00 : trit_in;

    // Next-state and output decode for the fill / hold handshake.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned; that is what keeps this block free of latches.
        state_d    = state_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        grp_d      = grp_q;
        idx_d      = idx_q;
        err_d      = err_q;
        trit_ready = 1'b0;
        grp_valid  = 1'b0;
        grp_last   = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pos_d   = 3'd0;
                    cnt_d   = 11'd0;
                    idx_d   = 8'd0;
                    grp_d   = 10'd0;
                    err_d   = 1'b0;
                    state_d = S_FILL;
                end
            end

            S_FILL: begin
                trit_ready = 1'b1;
                if (trit_valid) begin
                    case (pos_q)
                        3'd0:    grp_d[1:0] = trit_clean;
                        3'd1:    grp_d[3:2] = trit_clean;
                        3'd2:    grp_d[5:4] = trit_clean;
                        3'd3:    grp_d[7:6] = trit_clean;
                        default: grp_d[9:8] = trit_clean;
                    endcase
                    if (trit_bad) begin
                        err_d = 1'b1;
                    end
                    pos_d = pos_q + 3'd1;
                    cnt_d = cnt_q + 11'd1;
                    // A group closes when its fifth slot fills or when the
                    // polynomial runs out of coefficients (padded group).
                    if (pos_q == 3'd4 || cnt_d == N_LAST) begin
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                grp_valid = 1'b1;
                grp_last  = (cnt_q == N_LAST);
                if (grp_ready) begin
                    if (cnt_q == N_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        grp_d   = 10'd0;
                        pos_d   = 3'd0;
                        idx_d   = idx_q + 8'd1;
                        state_d = S_FILL;
                    end
                end
            end

            default: begin  // S_DONE
                done    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= S_IDLE;
            pos_q   <= 3'd0;
            cnt_q   <= 11'd0;
            grp_q   <= 10'd0;
            idx_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign grp         = grp_q;
    assign grp_index   = idx_q;
    assign busy        = (state_q != S_IDLE);
    assign err_illegal = err_q;

endmodule

// File: tb/tb_trit_group_packer.sv
// Directed bench for trit_group_packer. Three instances (5, 12 and 700
// coefficients) share the stimulus; each scenario resets them all and
// observes the instance it targets. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_trit_group_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] trit_in;
    logic       trit_valid;
    logic       grp_ready;

    logic [2:0] tr_a, gv_a, gl_a, bz_a, dn_a, er_a;
    logic [9:0] gp_a [3];
    logic [7:0] gi_a [3];

    always #5 clk = ~clk;

    trit_group_packer #(.N_TRITS(5)) u_n5 (
        .clk(clk), .rst_n(rst_n), .start(start), .trit_in(trit_in),
        .trit_valid(trit_valid), .trit_ready(tr_a[0]), .grp(gp_a[0]),
        .grp_valid(gv_a[0]), .grp_ready(grp_ready), .grp_last(gl_a[0]),
        .grp_index(gi_a[0]), .busy(bz_a[0]), .done(dn_a[0]), .err_illegal(er_a[0])
    );

    trit_group_packer #(.N_TRITS(12)) u_n12 (
        .clk(clk), .rst_n(rst_n), .start(start), .trit_in(trit_in),
        .trit_valid(trit_valid), .trit_ready(tr_a[1]), .grp(gp_a[1]),
        .grp_valid(gv_a[1]), .grp_ready(grp_ready), .grp_last(gl_a[1]),
        .grp_index(gi_a[1]), .busy(bz_a[1]), .done(dn_a[1]), .err_illegal(er_a[1])
    );

    trit_group_packer #(.N_TRITS(700)) u_n700 (
        .clk(clk), .rst_n(rst_n), .start(start), .trit_in(trit_in),
        .trit_valid(trit_valid), .trit_ready(tr_a[2]), .grp(gp_a[2]),
        .grp_valid(gv_a[2]), .grp_ready(grp_ready), .grp_last(gl_a[2]),
        .grp_index(gi_a[2]), .busy(bz_a[2]), .done(dn_a[2]), .err_illegal(er_a[2])
    );

    // Outputs of the instance under observation.
    logic [1:0] sel;
    logic       m_tr, m_gv, m_gl, m_bz, m_dn, m_er;
    logic [9:0] m_gp;
    logic [7:0] m_gi;
    assign m_tr = tr_a[sel];
    assign m_gv = gv_a[sel];
    assign m_gl = gl_a[sel];
    assign m_bz = bz_a[sel];
    assign m_dn = dn_a[sel];
    assign m_er = er_a[sel];
    assign m_gp = gp_a[sel];
    assign m_gi = gi_a[sel];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; trit_valid = 1'b0; grp_ready = 1'b0; trit_in = 2'b00;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_trit_ready"}, m_tr, 0);
        check({tag, "_grp_valid"},  m_gv, 0);
        check({tag, "_grp_last"},   m_gl, 0);
        check({tag, "_grp"},        m_gp, 0);
        check({tag, "_grp_index"},  m_gi, 0);
        check({tag, "_busy"},       m_bz, 0);
        check({tag, "_done"},       m_dn, 0);
        check({tag, "_err"},        m_er, 0);
    endtask

    // Offer one trit; returns on the falling edge after it was accepted.
    task automatic send_trit(input logic [1:0] t);
        int n;
        n = 0;
        trit_in    = t;
        trit_valid = 1'b1;
        while (!m_tr && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("send_timeout", m_tr, 1);
        tick();
        trit_valid = 1'b0;
    endtask

    // Take one group; returns on the falling edge after acceptance.
    task automatic recv_grp(output logic [9:0] g, output logic l, output logic [7:0] i);
        int n;
        n = 0;
        grp_ready = 1'b1;
        while (!m_gv && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("recv_timeout", m_gv, 1);
        g = m_gp;
        l = m_gl;
        i = m_gi;
        tick();
        grp_ready = 1'b0;
    endtask

    function automatic logic [1:0] enc(input int d);
        return (d == 2) ? 2'b11 : ((d == 1) ? 2'b01 : 2'b00);
    endfunction

    logic [9:0]  r_grp;
    logic        r_last;
    logic [7:0]  r_idx;
    logic [9:0]  pad_grp [3];
    int          digits [700];
    int          ti, gcnt, cyc, b3, ev, pw;
    logic [1:0]  code;
    logic [9:0]  eg;
    logic        seen_done;

    initial begin
        sel = 2'd0;
        rst_n = 1'b0; start = 1'b0; trit_in = 2'b00; trit_valid = 1'b0; grp_ready = 1'b0;
        tick();

        // ---------------- basic group, N_TRITS=5 ----------------
        sel = 2'd0;
        apply_reset();
        check_reset("rst0");
        do_start();
        check("basic_ready_after_start", m_tr, 1);
        check("basic_busy", m_bz, 1);
        send_trit(2'b01);
        send_trit(2'b11);
        send_trit(2'b00);
        send_trit(2'b01);
        send_trit(2'b11);
        check("basic_grp_valid", m_gv, 1);
        check("basic_grp", m_gp, 10'b11_01_00_11_01);
        check("basic_last", m_gl, 1);
        check("basic_index", m_gi, 0);
        check("basic_trit_ready_low", m_tr, 0);
        recv_grp(r_grp, r_last, r_idx);
        check("basic_done_pulse", m_dn, 1);
        tick();
        check("basic_done_clear", m_dn, 0);
        check("basic_idle", m_bz, 0);

        // ---------------- padding, N_TRITS=12 ----------------
        sel = 2'd1;
        pad_grp[0] = 10'h155;
        pad_grp[1] = 10'h155;
        pad_grp[2] = 10'b00_00_00_01_01;
        apply_reset();
        do_start();
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < ((g < 2) ? 5 : 2); k++) send_trit(2'b01);
            recv_grp(r_grp, r_last, r_idx);
            check("pad_grp", r_grp, pad_grp[g]);
            check("pad_index", r_idx, g);
            check("pad_last", r_last, (g == 2) ? 1 : 0);
        end
        check("pad_done", m_dn, 1);

        // ---------------- backpressure ----------------
        apply_reset();
        do_start();
        send_trit(2'b01);
        send_trit(2'b00);
        send_trit(2'b11);
        send_trit(2'b01);
        send_trit(2'b00);
        grp_ready  = 1'b0;
        trit_in    = 2'b11;
        trit_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            check("bp_valid", m_gv, 1);
            check("bp_grp", m_gp, 10'b00_01_11_00_01);
            check("bp_index", m_gi, 0);
            check("bp_trit_ready", m_tr, 0);
            tick();
        end
        grp_ready = 1'b1;
        tick();
        grp_ready = 1'b0;
        check("bp_ready_after_accept", m_tr, 1);
        check("bp_valid_drop", m_gv, 0);
        tick();
        trit_valid = 1'b0;
        for (int k = 0; k < 4; k++) send_trit(2'b00);
        check("bp_g1_valid", m_gv, 1);
        check("bp_g1_grp", m_gp, 10'h003);
        check("bp_g1_index", m_gi, 1);
        check("bp_g1_last", m_gl, 0);

        // ---------------- illegal encoding ----------------
        apply_reset();
        do_start();
        send_trit(2'b01);
        send_trit(2'b01);
        send_trit(2'b10);
        send_trit(2'b01);
        send_trit(2'b01);
        check("ill_grp", m_gp, 10'b01_01_00_01_01);
        check("ill_err_set", m_er, 1);
        recv_grp(r_grp, r_last, r_idx);
        for (int k = 0; k < 5; k++) send_trit(2'b00);
        recv_grp(r_grp, r_last, r_idx);
        check("ill_err_sticky", m_er, 1);
        send_trit(2'b01);
        send_trit(2'b01);
        recv_grp(r_grp, r_last, r_idx);
        check("ill_last_grp", r_grp, 10'h005);
        check("ill_done", m_dn, 1);
        check("ill_err_at_done", m_er, 1);
        tick();
        check("ill_err_idle", m_er, 1);
        do_start();
        check("ill_err_cleared", m_er, 0);
        check("ill_restart_ready", m_tr, 1);

        // ---------------- start ignored in FILL, reset in HOLD ----------------
        sel = 2'd2;
        apply_reset();
        do_start();
        send_trit(2'b11);
        send_trit(2'b01);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("st_busy", m_bz, 1);
        check("st_ready", m_tr, 1);
        check("st_index", m_gi, 0);
        send_trit(2'b00);
        send_trit(2'b11);
        send_trit(2'b01);
        recv_grp(r_grp, r_last, r_idx);
        check("st_grp0", r_grp, 10'b01_11_00_01_11);
        check("st_idx0", r_idx, 0);
        for (int g = 1; g < 3; g++) begin
            for (int k = 0; k < 5; k++) send_trit(2'b01);
            recv_grp(r_grp, r_last, r_idx);
            check("st_idx", r_idx, g);
        end
        for (int k = 0; k < 5; k++) send_trit(2'b11);
        check("st_g3_valid", m_gv, 1);
        check("st_g3_index", m_gi, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset("hold_rst");
        tick();
        check("hold_rst_no_done", m_dn, 0);
        check("hold_rst_no_valid", m_gv, 0);

        // ---------------- full polynomial, N_TRITS=700 ----------------
        for (int i = 0; i < 700; i++) digits[i] = $urandom_range(0, 2);
        apply_reset();
        do_start();
        ti = 0; gcnt = 0; cyc = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 20000) begin
            if (m_dn) begin
                seen_done = 1'b1;
            end else begin
                trit_valid = (ti < 700) && ($urandom_range(0, 3) != 0);
                trit_in    = (ti < 700) ? enc(digits[ti]) : 2'b00;
                grp_ready  = ($urandom_range(0, 2) != 0);
                if (trit_valid && m_tr) ti++;
                if (m_gv && grp_ready) begin
                    eg = 10'd0;
                    ev = 0;
                    pw = 1;
                    for (int k = 0; k < 5; k++) begin
                        eg[2*k +: 2] = enc(digits[5*gcnt + k]);
                        ev = ev + digits[5*gcnt + k] * pw;
                        pw = pw * 3;
                    end
                    b3 = 0;
                    pw = 1;
                    for (int k = 0; k < 5; k++) begin
                        code = m_gp[2*k +: 2];
                        b3 = b3 + ((code == 2'b11) ? 2 : int'(code)) * pw;
                        pw = pw * 3;
                    end
                    check("full_index", m_gi, gcnt);
                    check("full_last", m_gl, (gcnt == 139) ? 1 : 0);
                    check("full_grp", m_gp, eg);
                    check("full_byte", b3, ev);
                    check("full_le242", (b3 <= 242) ? 1 : 0, 1);
                    gcnt++;
                end
                tick();
                cyc++;
            end
        end
        trit_valid = 1'b0;
        grp_ready  = 1'b0;
        check("full_done_seen", seen_done, 1);
        check("full_group_count", gcnt, 140);
        check("full_trit_count", ti, 700);
        check("full_err_clear", m_er, 0);
        tick();
        check("full_idle", m_bz, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
